// File: rtl/cdc_pkg.sv
// Shared constants, types and helpers for the multi-channel CDC synchroniser bank.
package cdc_pkg;

    localparam int MIN_STAGES = 2;

    typedef enum logic [1:0] {EV_NONE, EV_RISE, EV_FALL} cdc_event_e;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cdc_sync_filt_ch.sv
// One channel: synchroniser chain, optional stable-count glitch filter, edge pulses.
module cdc_sync_filt_ch
    import cdc_pkg::*;
#(
    parameter int   STAGES        = 2,
    parameter int   FILTER_CYCLES = 3,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic clock,
    input  logic arst_n,
    input  logic din,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;
    logic sync_out;

    always_ff @(posedge clock) begin
        if (!arst_n) chain <= {STAGES{RST_VAL}};
        else         chain <= {chain[STAGES-2:0], din};
    end

    assign sync_out = chain[STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            // Delayed copy keeps the pulses aligned with the unfiltered level.
            logic sync_d;

            always_ff @(posedge clock) begin
                if (!arst_n) sync_d <= RST_VAL;
                else         sync_d <= sync_out;
            end

            assign dout       = sync_out;
            assign rise_pulse = sync_out & ~sync_d;
            assign fall_pulse = ~sync_out & sync_d;
        end else begin : g_filt
            localparam int             CW       = cnt_width(FILTER_CYCLES);
            localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          level;
            logic          rise_q;
            logic          fall_q;

            always_ff @(posedge clock) begin
                if (!arst_n) begin
                    level  <= RST_VAL;
                    cnt    <= '0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                    if (sync_out == level) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // Pulse registers update on the same edge as level so they coincide.
                        level  <= sync_out;
                        cnt    <= '0;
                        rise_q <= sync_out;
                        fall_q <= ~sync_out;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end

            assign dout       = level;
            assign rise_pulse = rise_q;
            assign fall_pulse = fall_q;
        end
    endgenerate

endmodule

// File: rtl/cdc_sync_bank.sv
// WIDTH independent single-bit synchroniser channels with level, edge pulses and a change summary.
module cdc_sync_bank
    import cdc_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               STAGES        = 2,
    parameter int               FILTER_CYCLES = 3,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clock,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             change_any
);

    generate
        if (STAGES < MIN_STAGES) begin : g_chk_stages
            $fatal(1, "cdc_sync_bank: STAGES must be >= %0d", MIN_STAGES);
        end
        if (FILTER_CYCLES < 0 || FILTER_CYCLES > 65535) begin : g_chk_filt
            $fatal(1, "cdc_sync_bank: FILTER_CYCLES out of range 0..65535");
        end
        if (WIDTH < 1) begin : g_chk_width
            $fatal(1, "cdc_sync_bank: WIDTH must be >= 1");
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            cdc_sync_filt_ch #(
                .STAGES        (STAGES),
                .FILTER_CYCLES (FILTER_CYCLES),
                .RST_VAL       (RESET_VAL[i])
            ) u_ch (
                .clock      (clock),
                .arst_n     (arst_n),
                .din        (din[i]),
                .dout       (dout[i]),
                .rise_pulse (rise_pulse[i]),
                .fall_pulse (fall_pulse[i])
            );
        end
    endgenerate

    assign change_any = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_cdc_sync_bank.sv
// Bench for cdc_sync_bank: filtered (2 stages, 3-cycle filter) and bypass (3 stages) instances.
module tb_cdc_sync_bank;
    import cdc_pkg::*;

    logic       clock = 1'b0;
    logic       arst_n = 1'b0;
    logic [3:0] din_a = 4'h0, din_b = 4'h0;
    logic [3:0] dout_a, rise_a, fall_a, dout_b, rise_b, fall_b;
    logic       chg_a, chg_b;

    int n_tests = 0;
    int n_fail  = 0;

    cdc_sync_bank #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VAL(4'h0)) dut_a (
        .clock(clock), .arst_n(arst_n), .din(din_a), .dout(dout_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .change_any(chg_a));

    cdc_sync_bank #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(0), .RESET_VAL(4'h0)) dut_b (
        .clock(clock), .arst_n(arst_n), .din(din_b), .dout(dout_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .change_any(chg_b));

    always #5 clock = ~clock;

    // Reference model: a delay line of sampled inputs, and a level that flips
    // only when the last fc synchronised samples all disagree with it.
    logic [3:0] m_dl  [2][8];
    logic [3:0] m_win [2][8];
    logic [3:0] exp_dout [2];
    logic [3:0] exp_rise [2];
    logic [3:0] exp_fall [2];

    initial begin
        for (int m = 0; m < 2; m++) begin
            exp_dout[m] = 4'h0; exp_rise[m] = 4'h0; exp_fall[m] = 4'h0;
            for (int k = 0; k < 8; k++) begin m_dl[m][k] = 4'h0; m_win[m][k] = 4'h0; end
        end
    end

    task automatic step_model(input int m, input int stages, input int fc,
                              input logic rst_n, input logic [3:0] d);
        logic [3:0] old_d, sync_pre, flip, new_d;
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin m_dl[m][k] = 4'h0; m_win[m][k] = 4'h0; end
            exp_dout[m] = 4'h0; exp_rise[m] = 4'h0; exp_fall[m] = 4'h0;
        end else begin
            old_d    = exp_dout[m];
            sync_pre = m_dl[m][stages-1];
            new_d    = old_d;
            if (fc > 0) begin
                for (int k = fc - 1; k > 0; k--) m_win[m][k] = m_win[m][k-1];
                m_win[m][0] = sync_pre;
                flip = 4'hF;
                for (int k = 0; k < fc; k++) flip = flip & (m_win[m][k] ^ old_d);
                new_d = old_d ^ flip;
            end
            for (int k = stages - 1; k > 0; k--) m_dl[m][k] = m_dl[m][k-1];
            m_dl[m][0] = d;
            if (fc == 0) new_d = m_dl[m][stages-1];
            exp_dout[m] = new_d;
            exp_rise[m] = new_d & ~old_d;
            exp_fall[m] = ~new_d & old_d;
        end
    endtask

    always @(posedge clock) begin
        step_model(0, 2, 3, arst_n, din_a);
        step_model(1, 3, 0, arst_n, din_b);
    end

    function automatic cdc_event_e ev_of(input logic r, input logic f);
        if (r) return EV_RISE;
        if (f) return EV_FALL;
        return EV_NONE;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        int chg_cnt;
        din_a = 4'hF; din_b = 4'h0; arst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if ({dout_a, rise_a, fall_a, chg_a} !== 13'h0) begin
                n_fail++;
                $display("FAIL reset_hold: dout=%h rise=%h fall=%h chg=%b want all 0", dout_a, rise_a, fall_a, chg_a);
            end
        end
        arst_n = 1'b1;
        chg_cnt = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (chg_a === 1'b1) chg_cnt++;
            n_tests++;
            if (dout_a !== ((t >= 5) ? 4'hF : 4'h0) || rise_a !== ((t == 5) ? 4'hF : 4'h0) || fall_a !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_release t=%0d: dout=%h rise=%h fall=%h", t, dout_a, rise_a, fall_a);
            end
        end
        n_tests++;
        if (chg_cnt != 1) begin
            n_fail++;
            $display("FAIL reset_change_any: count=%0d want 1", chg_cnt);
        end
    endtask

    task automatic test_single_rise();
        din_a = 4'h0;
        repeat (8) tick();
        din_a = 4'h1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            n_tests++;
            if (dout_a !== ((t >= 5) ? 4'h1 : 4'h0) || rise_a !== ((t == 5) ? 4'h1 : 4'h0) || fall_a !== 4'h0) begin
                n_fail++;
                $display("FAIL single_rise t=%0d: dout=%h rise=%h fall=%h", t, dout_a, rise_a, fall_a);
            end
        end
    endtask

    task automatic test_glitch();
        cdc_event_e evq[$];
        int rise_t, fall_t;
        din_a = 4'h3; tick(); tick(); din_a = 4'h1;
        for (int t = 0; t < 8; t++) begin
            tick();
            n_tests++;
            if (dout_a !== 4'h1 || rise_a !== 4'h0 || fall_a !== 4'h0) begin
                n_fail++;
                $display("FAIL glitch_short t=%0d: dout=%h rise=%h fall=%h want 1/0/0", t, dout_a, rise_a, fall_a);
            end
        end
        din_a = 4'h3;
        rise_t = -1; fall_t = -1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (ev_of(rise_a[1], fall_a[1]) != EV_NONE) evq.push_back(ev_of(rise_a[1], fall_a[1]));
            if (rise_a[1] === 1'b1) rise_t = t;
            if (fall_a[1] === 1'b1) fall_t = t;
            if (t == 3) din_a = 4'h1;
        end
        n_tests++;
        if (evq.size() != 2 || evq[0] != EV_RISE || evq[1] != EV_FALL) begin
            n_fail++;
            $display("FAIL glitch_events: got %0d events want rise then fall", evq.size());
        end
        n_tests++;
        if (rise_t != 5 || fall_t != 8) begin
            n_fail++;
            $display("FAIL glitch_timing: rise_t=%0d fall_t=%0d want 5 and 8", rise_t, fall_t);
        end
    endtask

    task automatic test_simultaneous();
        int chg_cnt;
        din_a = 4'h4;
        repeat (8) tick();
        n_tests++;
        if (dout_a !== 4'h4) begin
            n_fail++;
            $display("FAIL simul_pre: dout=%h want 4", dout_a);
        end
        din_a = 4'h8;
        chg_cnt = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (chg_a === 1'b1) chg_cnt++;
            n_tests++;
            if (dout_a !== ((t >= 5) ? 4'h8 : 4'h4) || rise_a !== ((t == 5) ? 4'h8 : 4'h0) ||
                fall_a !== ((t == 5) ? 4'h4 : 4'h0)) begin
                n_fail++;
                $display("FAIL simul t=%0d: dout=%h rise=%h fall=%h", t, dout_a, rise_a, fall_a);
            end
        end
        n_tests++;
        if (chg_cnt != 1) begin
            n_fail++;
            $display("FAIL simul_change_any: count=%0d want 1", chg_cnt);
        end
    endtask

    task automatic test_reset_mid_filter();
        din_a = 4'h0;
        repeat (8) tick();
        din_a = 4'h1;
        repeat (4) tick();
        arst_n = 1'b0;
        tick();
        n_tests++;
        if (dout_a !== 4'h0 || rise_a !== 4'h0 || fall_a !== 4'h0 || chg_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_reset_cycle: dout=%h rise=%h fall=%h chg=%b", dout_a, rise_a, fall_a, chg_a);
        end
        arst_n = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            n_tests++;
            if (dout_a !== ((t >= 5) ? 4'h1 : 4'h0) || rise_a !== ((t == 5) ? 4'h1 : 4'h0) || fall_a !== 4'h0) begin
                n_fail++;
                $display("FAIL midrst_release t=%0d: dout=%h rise=%h fall=%h", t, dout_a, rise_a, fall_a);
            end
        end
    endtask

    task automatic test_bypass();
        din_b = 4'h0;
        repeat (6) tick();
        din_b = 4'h1;
        for (int t = 1; t <= 5; t++) begin
            tick();
            n_tests++;
            if (dout_b !== ((t >= 3) ? 4'h1 : 4'h0) || rise_b !== ((t == 3) ? 4'h1 : 4'h0) ||
                chg_b !== (t == 3) || fall_b !== 4'h0) begin
                n_fail++;
                $display("FAIL bypass_rise t=%0d: dout=%h rise=%h fall=%h chg=%b", t, dout_b, rise_b, fall_b, chg_b);
            end
        end
        din_b = 4'h0;
        repeat (6) tick();
        din_b = 4'h1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            n_tests++;
            if (dout_b !== ((t == 3) ? 4'h1 : 4'h0) || rise_b !== ((t == 3) ? 4'h1 : 4'h0) ||
                fall_b !== ((t == 4) ? 4'h1 : 4'h0)) begin
                n_fail++;
                $display("FAIL bypass_glitch t=%0d: dout=%h rise=%h fall=%h", t, dout_b, rise_b, fall_b);
            end
            if (t == 1) din_b = 4'h0;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            tick();
            n_tests++;
            if (dout_a !== exp_dout[0] || rise_a !== exp_rise[0] || fall_a !== exp_fall[0] ||
                chg_a !== |{exp_rise[0], exp_fall[0]}) begin
                n_fail++;
                $display("FAIL random_filt c=%0d: dout=%h/%h rise=%h/%h fall=%h/%h (got/want)",
                         c, dout_a, exp_dout[0], rise_a, exp_rise[0], fall_a, exp_fall[0]);
            end
            n_tests++;
            if (dout_b !== exp_dout[1] || rise_b !== exp_rise[1] || fall_b !== exp_fall[1] ||
                chg_b !== |{exp_rise[1], exp_fall[1]}) begin
                n_fail++;
                $display("FAIL random_byp c=%0d: dout=%h/%h rise=%h/%h fall=%h/%h (got/want)",
                         c, dout_b, exp_dout[1], rise_b, exp_rise[1], fall_b, exp_fall[1]);
            end
            if ($urandom_range(0, 3) == 0) din_a = din_a ^ 4'($urandom & $urandom);
            if ($urandom_range(0, 2) == 0) din_b = din_b ^ 4'($urandom & $urandom);
            arst_n = ($urandom_range(0, 79) != 0);
        end
        arst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_glitch();
        test_simultaneous();
        test_reset_mid_filter();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
